// File: rtl/multicycle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_pkg
// Description : Shared encodings for the multicycle RV32I-subset control path.
//               Contains the main FSM state type, the ALU operation codes, the
//               opcode constants, the datapath mux select encodings and a
//               small helper that recognises the supported ALU funct3 values.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_pkg;

    // Main FSM states
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Main decoder to ALU decoder operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Opcodes (instr[6:0])
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // Datapath mux selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Position of the zero flag inside {n,z,c,v}
    localparam int FLAG_Z = 2;

    // funct3 values the ALU can execute: add/sub, slt, or, and
    function automatic logic funct3_is_alu(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Combinational ALU decoder. Maps the main FSM's alu_op class
//               plus the instruction funct fields onto an ALU operation code.
// Ports       : alu_op[1:0]      operation class from the main FSM
//               funct3[2:0]      instr[14:12]
//               op5              instr[5], distinguishes R-type from I-type
//               funct7b5         instr[30]
//               alu_control[2:0] ALU operation code
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import multicycle_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only register-register ops honour funct7b5; addi never subtracts
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default:   alu_control = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Control unit of the multicycle RV32I-subset core. A Moore main
//               FSM sequences fetch/decode/execute/memory/writeback and drives
//               every datapath select and enable; the ALU decoder turns the
//               FSM's alu_op plus funct fields into alu_control.
// Ports       : clk, reset (sync, active-high)
//               op, funct3, funct7b5  instruction fields from the IR
//               flags                 ALU flags {n,z,c,v}
//               pc_write, adr_src, mem_write, ir_write, result_src,
//               alu_src_a, alu_src_b, imm_src, reg_write, alu_control
//                                     datapath controls
//               illegal_instr, instr_retired  status pulses
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [3:0] flags,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [2:0] alu_control,
    output logic       illegal_instr,
    output logic       instr_retired
);

    state_t     r_state;
    state_t     w_state;
    state_t     w_next;
    logic       w_bad;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_illegal;
    logic       w_retire;
    logic [1:0] w_alu_op;
    logic       w_unused_flags;

    // Only the zero flag steers control
    assign w_unused_flags = ^{flags[3], flags[1:0]};

    // Instruction legality, evaluated only in DECODE
    always_comb begin
        w_bad = 1'b0;
        case (op)
            OP_LW, OP_SW: w_bad = (funct3 != 3'b010);
            OP_BEQ:       w_bad = (funct3 != 3'b000);
            OP_RTYPE:     w_bad = !funct3_is_alu(funct3) || (funct7b5 && (funct3 != 3'b000));
            OP_ITYPE:     w_bad = !funct3_is_alu(funct3);
            OP_JAL:       w_bad = 1'b0;
            default:      w_bad = 1'b1;
        endcase
    end

    // Immediate format depends on the opcode alone
    always_comb begin
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

    // Main FSM output and next-state decode. While reset is high the decode
    // looks at FETCH so the non-enable outputs already show FETCH values.
    always_comb begin
        w_state     = reset ? FETCH : r_state;
        w_next      = FETCH;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        w_retire    = 1'b0;
        w_alu_op    = ALUOP_ADD;
        adr_src     = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RD2;
        case (w_state)
            FETCH: begin
                w_ir_write  = 1'b1;
                alu_src_a   = SRCA_PC;
                alu_src_b   = SRCB_FOUR;
                result_src  = RES_ALURESULT;
                w_pc_update = 1'b1;
                w_next      = DECODE;
            end
            DECODE: begin
                // Precompute the branch target into ALUOut
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                if (w_bad) begin
                    w_illegal = 1'b1;
                    w_next    = FETCH;
                end else begin
                    case (op)
                        OP_LW, OP_SW: w_next = MEMADR;
                        OP_RTYPE:     w_next = EXECUTER;
                        OP_ITYPE:     w_next = EXECUTEI;
                        OP_BEQ:       w_next = BEQ;
                        OP_JAL:       w_next = JAL;
                        default:      w_next = FETCH;
                    endcase
                end
            end
            MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                w_next    = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                w_next     = MEMWB;
            end
            MEMWB: begin
                result_src  = RES_DATA;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = FETCH;
            end
            MEMWRITE: begin
                adr_src     = 1'b1;
                result_src  = RES_ALUOUT;
                w_mem_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = FETCH;
            end
            EXECUTER: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_RD2;
                w_alu_op  = ALUOP_FUNCT;
                w_next    = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                w_alu_op  = ALUOP_FUNCT;
                w_next    = ALUWB;
            end
            ALUWB: begin
                result_src  = RES_ALUOUT;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = FETCH;
            end
            BEQ: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_RD2;
                w_alu_op   = ALUOP_SUB;
                result_src = RES_ALUOUT;
                w_branch   = 1'b1;
                w_retire   = 1'b1;
                w_next     = FETCH;
            end
            JAL: begin
                // Jump target sits in ALUOut; compute PC+4 for the link write
                alu_src_a   = SRCA_OLDPC;
                alu_src_b   = SRCB_FOUR;
                result_src  = RES_ALUOUT;
                w_pc_update = 1'b1;
                w_next      = ALUWB;
            end
            default: begin
                w_next = FETCH;
            end
        endcase
    end

    // Enables and status pulses are suppressed during reset
    assign pc_write      = !reset && (w_pc_update || (w_branch && flags[FLAG_Z]));
    assign ir_write      = !reset && w_ir_write;
    assign mem_write     = !reset && w_mem_write;
    assign reg_write     = !reset && w_reg_write;
    assign illegal_instr = !reset && w_illegal;
    assign instr_retired = !reset && w_retire;

    alu_decoder u_alu_decoder (
        .alu_op      (w_alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. A reference model
//               classifies each instruction and derives the expected control
//               word for every cycle of it; a vector table, hand sequences for
//               reset corner cases and randomized instructions drive the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [3:0] flags;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [2:0] alu_control;
    logic       illegal_instr;
    logic       instr_retired;

    int checks = 0;
    int errors = 0;

    // Instruction classes
    localparam int c_k_lw  = 0;
    localparam int c_k_sw  = 1;
    localparam int c_k_r   = 2;
    localparam int c_k_i   = 3;
    localparam int c_k_beq = 4;
    localparam int c_k_jal = 5;
    localparam int c_k_ill = 6;

    multicycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .flags         (flags),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .imm_src       (imm_src),
        .reg_write     (reg_write),
        .alu_control   (alu_control),
        .illegal_instr (illegal_instr),
        .instr_retired (instr_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int classify(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        bit alu_ok;
        alu_ok = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
        if (o == 7'h03) return (f3 == 3'd2) ? c_k_lw : c_k_ill;
        if (o == 7'h23) return (f3 == 3'd2) ? c_k_sw : c_k_ill;
        if (o == 7'h63) return (f3 == 3'd0) ? c_k_beq : c_k_ill;
        if (o == 7'h6f) return c_k_jal;
        if (o == 7'h13) return alu_ok ? c_k_i : c_k_ill;
        if (o == 7'h33) return (alu_ok && !(f7 && f3 != 3'd0)) ? c_k_r : c_k_ill;
        return c_k_ill;
    endfunction

    function automatic int kind_len(input int k);
        case (k)
            c_k_lw:  return 5;
            c_k_sw:  return 4;
            c_k_beq: return 3;
            c_k_ill: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input int k, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (k == c_k_r && f7) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Packed control word:
    // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
    //  alu_src_b, imm_src, reg_write, alu_control, illegal_instr, instr_retired}
    function automatic logic [17:0] model(input int k, input int step, input logic [6:0] o,
                                          input logic [2:0] f3, input logic f7,
                                          input logic [3:0] fl, input bit in_reset);
        logic pcw, adr, mw, irw, rw, ill, ret;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
        {pcw, adr, mw, irw, rw, ill, ret} = '0;
        rs = 2'd0; sa = 2'd0; sb = 2'd0; alu = 3'd0;
        imm = (o == 7'h23) ? 2'd1 : (o == 7'h63) ? 2'd2 : (o == 7'h6f) ? 2'd3 : 2'd0;
        if (in_reset || step == 0 || step >= kind_len(k)) begin
            // fetch: PC <= PC + 4, latch instruction
            sb = 2'd2; rs = 2'd2;
            pcw = !in_reset; irw = !in_reset;
        end else if (step == 1) begin
            sa = 2'd1; sb = 2'd1;
            ill = (k == c_k_ill);
        end else begin
            case (k)
                c_k_lw, c_k_sw: begin
                    if (step == 2) begin sa = 2'd2; sb = 2'd1; end
                    else if (k == c_k_sw) begin adr = 1'b1; mw = 1'b1; ret = 1'b1; end
                    else if (step == 3) adr = 1'b1;
                    else begin rs = 2'd1; rw = 1'b1; ret = 1'b1; end
                end
                c_k_r, c_k_i: begin
                    if (step == 2) begin
                        sa = 2'd2; sb = (k == c_k_r) ? 2'd0 : 2'd1;
                        alu = funct_alu(k, f3, f7);
                    end else begin rw = 1'b1; ret = 1'b1; end
                end
                c_k_beq: begin
                    sa = 2'd2; alu = 3'b001; pcw = fl[2]; ret = 1'b1;
                end
                c_k_jal: begin
                    if (step == 2) begin sa = 2'd1; sb = 2'd2; pcw = 1'b1; end
                    else begin rw = 1'b1; ret = 1'b1; end
                end
                default: ;
            endcase
        end
        return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, alu, ill, ret};
    endfunction

    function automatic logic [17:0] dut_word();
        return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, imm_src, reg_write, alu_control, illegal_instr, instr_retired};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one instruction starting in a FETCH cycle; leaves the bench inside
    // the following FETCH cycle. Every cycle's control word is checked.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic [3:0] fl, input bit rnd,
                             output int len, output logic [2:0] alu2, output logic pcw2);
        int k;
        k = classify(o, f3, f7);
        op = o; funct3 = f3; funct7b5 = f7;
        flags = rnd ? 4'($urandom) : fl;
        len = 99; alu2 = 3'd0; pcw2 = 1'b0;
        #1;
        for (int s = 0; s <= 12; s++) begin
            if (s > 0) begin
                @(posedge clk);
                #1;
                if (rnd) flags = 4'($urandom);
                #3;
                if (ir_write) begin
                    len = s;
                    break;
                end
            end
            chk($sformatf("ctrl k%0d step%0d op%h f3%0d", k, s, o, f3),
                32'(dut_word()), 32'(model(k, s, o, f3, f7, flags, 1'b0)));
            if (s == 2) begin
                alu2 = alu_control;
                pcw2 = pc_write;
            end
        end
        if (len == 99) chk("instr_timeout", 32'd99, 32'(kind_len(k)));
    endtask

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [3:0] fl;
        int         len;
        logic [2:0] alu2;
        logic       pcw2;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int         len;
        logic [2:0] a2;
        logic       p2;
        logic [6:0] ops[6];

        vecs[0]  = '{7'h03, 3'd2, 1'b0, 4'b0000, 5, 3'b000, 1'b0}; // lw
        vecs[1]  = '{7'h33, 3'd0, 1'b1, 4'b0000, 4, 3'b001, 1'b0}; // sub
        vecs[2]  = '{7'h13, 3'd0, 1'b1, 4'b0000, 4, 3'b000, 1'b0}; // addi, f7b5 ignored
        vecs[3]  = '{7'h33, 3'd2, 1'b0, 4'b0000, 4, 3'b101, 1'b0}; // slt
        vecs[4]  = '{7'h33, 3'd6, 1'b0, 4'b0000, 4, 3'b011, 1'b0}; // or
        vecs[5]  = '{7'h33, 3'd7, 1'b0, 4'b0000, 4, 3'b010, 1'b0}; // and
        vecs[6]  = '{7'h63, 3'd0, 1'b0, 4'b0100, 3, 3'b001, 1'b1}; // beq taken
        vecs[7]  = '{7'h63, 3'd0, 1'b0, 4'b0000, 3, 3'b001, 1'b0}; // beq not taken
        vecs[8]  = '{7'h63, 3'd0, 1'b0, 4'b1011, 3, 3'b001, 1'b0}; // other flags only
        vecs[9]  = '{7'h23, 3'd2, 1'b0, 4'b0000, 4, 3'b000, 1'b0}; // sw
        vecs[10] = '{7'h6f, 3'd5, 1'b1, 4'b0000, 4, 3'b000, 1'b1}; // jal
        vecs[11] = '{7'h00, 3'd0, 1'b0, 4'b0000, 2, 3'b000, 1'b0}; // unknown op
        vecs[12] = '{7'h33, 3'd1, 1'b0, 4'b0000, 2, 3'b000, 1'b0}; // bad R funct3
        vecs[13] = '{7'h33, 3'd2, 1'b1, 4'b0000, 2, 3'b000, 1'b0}; // f7b5 on non-add
        vecs[14] = '{7'h03, 3'd0, 1'b0, 4'b0000, 2, 3'b000, 1'b0}; // lw bad funct3
        vecs[15] = '{7'h13, 3'd7, 1'b1, 4'b0000, 4, 3'b010, 1'b0}; // andi

        // Reset held for three cycles with a lw in the IR
        reset = 1'b1; op = 7'h03; funct3 = 3'd2; funct7b5 = 1'b0; flags = 4'b0100;
        repeat (3) begin
            @(negedge clk);
            chk("reset_ctrl", 32'(dut_word()), 32'(model(c_k_lw, 0, op, funct3, funct7b5, flags, 1'b1)));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        run_instr(7'h03, 3'd2, 1'b0, 4'b0000, 1'b0, len, a2, p2);
        chk("lw_after_reset_len", 32'(len), 32'd5);

        // Table-driven vectors
        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].fl, 1'b0, len, a2, p2);
            chk($sformatf("vec%0d_len", i), 32'(len), 32'(vecs[i].len));
            if (vecs[i].len > 2) begin
                chk($sformatf("vec%0d_alu", i), 32'(a2), 32'(vecs[i].alu2));
                chk($sformatf("vec%0d_pcw", i), 32'(p2), 32'(vecs[i].pcw2));
            end
        end

        // Reset asserted while a lw sits in MEMREAD
        op = 7'h03; funct3 = 3'd2; funct7b5 = 1'b0; flags = 4'b0000;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #1;
        chk("memread_before_reset", 32'(dut_word()), 32'(model(c_k_lw, 3, op, funct3, funct7b5, flags, 1'b0)));
        reset = 1'b1;
        #1;
        chk("memread_reset_ctrl", 32'(dut_word()), 32'(model(c_k_lw, 0, op, funct3, funct7b5, flags, 1'b1)));
        @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        chk("after_reset_fetch", 32'(dut_word()), 32'(model(c_k_lw, 0, op, funct3, funct7b5, flags, 1'b0)));
        run_instr(7'h33, 3'd0, 1'b0, 4'b0000, 1'b0, len, a2, p2);
        chk("resume_len", 32'(len), 32'd4);

        // Randomized instruction stream with random flags every cycle
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f};
        for (int n = 0; n < 300; n++) begin
            logic [6:0] o;
            logic [2:0] f3;
            logic       f7;
            o  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
            f3 = 3'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                if (o == 7'h03 || o == 7'h23) f3 = 3'd2;
                else if (o == 7'h63) f3 = 3'd0;
            end
            f7 = 1'($urandom);
            run_instr(o, f3, f7, 4'b0000, 1'b1, len, a2, p2);
            chk($sformatf("rand%0d_len", n), 32'(len), 32'(kind_len(classify(o, f3, f7))));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Control unit for the multicycle RV32I-subset processor. It is the producer of the ALU's `alu_control` bus and the consumer of its `flags` bus. A Moore main FSM sequences fetch, decode, execute, memory and writeback, and drives every datapath mux select and write enable. A combinational ALU decoder maps the FSM's `alu_op` plus `funct` fields onto the ALU operation codes.

Parameters:
None. All encodings are fixed package constants.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
op  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
flags  in  4  ALU flags {n,z,c,v}; bit 2 = zero
pc_write  out  1  PC register enable
adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  out  1  data memory write enable
ir_write  out  1  instruction/OldPC register enable
result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
alu_src_a  out  2  00 PC, 01 OldPC, 10 rd1
alu_src_b  out  2  00 rd2, 01 imm, 10 constant 4
imm_src  out  2  00 I, 01 S, 10 B, 11 J
reg_write  out  1  register file write enable
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
illegal_instr  out  1  one-cycle pulse on an undecodable instruction
instr_retired  out  1  one-cycle pulse on the last cycle of each instruction

Behaviour:
- One clock. Reset is synchronous and active-high. The state register loads FETCH on the edge where reset=1.
- While reset=1, pc_write, mem_write, ir_write, reg_write, illegal_instr and instr_retired are forced to 0. The other outputs take their FETCH values (srcA 00, srcB 10, result_src 10, alu_control 000, adr_src 0).
- Outputs are a pure function of state, op, funct3, funct7b5 and flags. No output registers.
- pc_write = pc_update | (branch & flags[2]).
- imm_src is decoded from op alone in every state: lw/ALU-imm → 00, sw → 01, beq → 10, jal → 11, otherwise 00.
- State outputs (unlisted controls are 0):
  - FETCH: adr_src 0, ir_write, srcA 00, srcB 10, alu_op 00, result_src 10, pc_update → DECODE
  - DECODE: srcA 01, srcB 01, alu_op 00 (branch target into ALUOut). Next state by op: 0000011/0100011 → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1100011 → BEQ; 1101111 → JAL.
  - DECODE illegal check: unknown op; lw/sw funct3≠010; beq funct3≠000; R/I funct3 ∉ {000,010,110,111}; R-type funct7b5=1 with funct3≠000. Any of these: illegal_instr=1 for this cycle, next state FETCH.
  - MEMADR: srcA 10, srcB 01, alu_op 00 → MEMREAD if op[5]=0, else MEMWRITE
  - MEMREAD: adr_src 1, result_src 00 → MEMWB
  - MEMWB: result_src 01, reg_write, instr_retired → FETCH
  - MEMWRITE: adr_src 1, result_src 00, mem_write, instr_retired → FETCH
  - EXECUTER: srcA 10, srcB 00, alu_op 10 → ALUWB
  - EXECUTEI: srcA 10, srcB 01, alu_op 10 → ALUWB
  - ALUWB: result_src 00, reg_write, instr_retired → FETCH
  - BEQ: srcA 10, srcB 00, alu_op 01, result_src 00, branch, instr_retired → FETCH
  - JAL: srcA 01, srcB 10, alu_op 00, result_src 00, pc_update → ALUWB (rd ← PC+4)
- ALU decoder:
  - alu_op 00 → 000; alu_op 01 → 001
  - alu_op 10 with funct3 000 → 001 if (op[5] & funct7b5), else 000
  - alu_op 10 with funct3 010 → 101, 110 → 011, 111 → 010, others → 000
  - alu_op 11 → 000
- Cycle counts: lw 5, sw 4, R/I 4, beq 3, jal 4, illegal 2.
- Reset mid-instruction: abandon the instruction, no write enable fires during the reset cycle, restart at FETCH.
- flags values other than flags[2] are ignored. X on op/funct while in FETCH must not affect any output.

Decomposition:
- Package multicycle_pkg:
  - state enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL)
  - ALU_ADD/SUB/AND/OR/SLT codes
  - opcode constants
  - SRCA_*, SRCB_*, RES_*, IMM_* select encodings
  - FLAG_Z index = 2
- Sub-module: alu_decoder (combinational; inputs alu_op, funct3, op5, funct7b5; output alu_control), shared with the single-cycle core.

Test Plan:
- Reset held 3 cycles then released, op=0000011 funct3=010 (lw) → no enables during reset; states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; reg_write only in cycle 5 with result_src=01; instr_retired pulses once.
- R-type sub (op 0110011, funct3 000, funct7b5 1) → alu_control 001 in EXECUTER; addi with funct7b5=1 (op 0010011) → 000; funct3 010 → 101; 110 → 011; 111 → 010.
- beq with flags=4'b0100 → pc_write=1 in BEQ, 3-cycle instruction; flags=4'b0000 → pc_write=0; flags=4'b1011 → pc_write=0.
- sw (op 0100011, funct3 010) → imm_src 01 in MEMADR, mem_write=1 with adr_src=1 in cycle 4 only, reg_write never asserted.
- jal (op 1101111) → pc_write in JAL with srcA 01, srcB 10; reg_write in ALUWB; imm_src 11 throughout.
- op=0000000 → illegal_instr=1 for exactly one DECODE cycle, back to FETCH. Separately, reset asserted in MEMREAD → next cycle FETCH, no reg_write.
